// File: rtl/fifo_sync_prog_if.sv
// fifo_sync_prog_if: write/read handshake, thresholds and status of the single-clock FIFO
interface fifo_sync_prog_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  w_en;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_full;
   logic                  w_afull;
   logic                  w_ovf;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_empty;
   logic                  r_aempty;
   logic                  r_unf;
   logic [ADDR_WIDTH:0]   i_afull_th;
   logic [ADDR_WIDTH:0]   i_aempty_th;
   logic [ADDR_WIDTH:0]   count;
   modport slave (
      input  w_en, w_data, r_en, i_afull_th, i_aempty_th,
      output w_full, w_afull, w_ovf, r_data, r_valid, r_empty, r_aempty, r_unf, count
   );
   modport master (
      output w_en, w_data, r_en, i_afull_th, i_aempty_th,
      input  w_full, w_afull, w_ovf, r_data, r_valid, r_empty, r_aempty, r_unf, count
   );
endinterface

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with occupancy count, programmable almost flags, error pulses and optional FWFT
module fifo_sync_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter bit FWFT       = 1'b0
) (
   input logic            i_clk,
   input logic            i_rst,
   fifo_sync_prog_if.slave f
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] one = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] full_cnt = (ADDR_WIDTH + 1)'(DEPTH);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wptr, rptr, cnt;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid, ovf, unf, wr_ok, rd_ok;
   assign wr_ok      = f.w_en & ~f.w_full;
   assign rd_ok      = f.r_en & ~f.r_empty;
   assign f.count    = cnt;
   assign f.w_full   = cnt == full_cnt;
   assign f.r_empty  = cnt == '0;
   assign f.w_afull  = cnt >= f.i_afull_th;
   assign f.r_aempty = cnt <= f.i_aempty_th;
   assign f.w_ovf    = ovf;
   assign f.r_unf    = unf;
   assign f.r_data   = FWFT ? mem[rptr[ADDR_WIDTH-1:0]] : rdata;
   assign f.r_valid  = FWFT ? ~f.r_empty : rvalid;
   always_ff @(posedge i_clk) begin
      if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= f.w_data;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr   <= '0;
         rptr   <= '0;
         cnt    <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + one;
         if (rd_ok) rptr <= rptr + one;
         cnt    <= (wr_ok & ~rd_ok) ? cnt + one : (rd_ok & ~wr_ok) ? cnt - one : cnt;
         ovf    <= f.w_en & f.w_full;
         unf    <= f.r_en & f.r_empty;
         rvalid <= rd_ok;
         if (rd_ok) rdata <= mem[rptr[ADDR_WIDTH-1:0]];
      end
   end
endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: directed table, corner sequences and random traffic against a queue model, both read modes
module tb_fifo_sync_prog;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we = 1'b0, re = 1'b0;
   logic [7:0] wd = '0;
   logic [3:0] aft = 4'd6, aet = 4'd2;
   int         total = 0, pass = 0;
   logic [7:0] mq [$];
   logic [7:0] e_rdata;
   logic       e_rvalid, e_ovf, e_unf;

   always #5 clk = ~clk;

   fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) fa ();
   fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) fb ();

   assign fa.w_en = we;  assign fa.w_data = wd;  assign fa.r_en = re;
   assign fa.i_afull_th = aft;  assign fa.i_aempty_th = aet;
   assign fb.w_en = we;  assign fb.w_data = wd;  assign fb.r_en = re;
   assign fb.i_afull_th = aft;  assign fb.i_aempty_th = aet;

   fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .f(fa.slave));
   fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .f(fb.slave));

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endfunction

   function automatic void check_all();
      int n = mq.size();
      chk("count", 32'(fa.count), 32'(n));
      chk("w_full", 32'(fa.w_full), 32'(n == 8));
      chk("r_empty", 32'(fa.r_empty), 32'(n == 0));
      chk("w_afull", 32'(fa.w_afull), 32'(n >= int'(aft)));
      chk("r_aempty", 32'(fa.r_aempty), 32'(n <= int'(aet)));
      chk("w_ovf", 32'(fa.w_ovf), 32'(e_ovf));
      chk("r_unf", 32'(fa.r_unf), 32'(e_unf));
      chk("r_valid", 32'(fa.r_valid), 32'(e_rvalid));
      chk("r_data", 32'(fa.r_data), 32'(e_rdata));
      chk("fwft_count", 32'(fb.count), 32'(n));
      chk("fwft_ovf", 32'(fb.w_ovf), 32'(e_ovf));
      chk("fwft_unf", 32'(fb.r_unf), 32'(e_unf));
      chk("fwft_r_valid", 32'(fb.r_valid), 32'(n > 0));
      if (n > 0) chk("fwft_r_data", 32'(fb.r_data), 32'(mq[0]));
   endfunction

   task automatic cyc(input logic we_i, input logic [7:0] wd_i, input logic re_i);
      int n;
      bit wok, rok;
      we = we_i; wd = wd_i; re = re_i;
      n = mq.size();
      wok = we_i && n < 8;
      rok = re_i && n > 0;
      e_ovf = we_i && n == 8;
      e_unf = re_i && n == 0;
      e_rvalid = rok;
      if (rok) e_rdata = mq.pop_front();
      if (wok) mq.push_back(wd_i);
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mq.delete();
      e_rdata = '0; e_rvalid = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_all();
   endtask

   typedef struct {
      logic       we;
      logic       re;
      logic [7:0] wd;
      int         cnt;
      logic       full;
      logic       ovf;
      logic       rvalid;
      logic [7:0] rdata;
   } vec_t;
   vec_t tv [18];

   initial begin
      for (int i = 0; i < 8; i++) tv[i] = '{1'b1, 1'b0, 8'(17 * (i + 1)), i + 1, i == 7, 1'b0, 1'b0, 8'h00};
      tv[8] = '{1'b1, 1'b0, 8'h99, 8, 1'b1, 1'b1, 1'b0, 8'h00};
      for (int i = 0; i < 8; i++) tv[9 + i] = '{1'b0, 1'b1, 8'h00, 7 - i, 1'b0, 1'b0, 1'b1, 8'(17 * (i + 1))};
      tv[17] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h88};

      aft = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      chk("afull_th0_at_reset", 32'(fa.w_afull), 32'd1);
      chk("reset_r_data", 32'(fa.r_data), 32'h0);
      aft = 4'd6; aet = 4'd2;
      cyc(1'b0, 8'h00, 1'b0);

      do_reset();
      for (int i = 0; i < 18; i++) begin
         cyc(tv[i].we, tv[i].wd, tv[i].re);
         chk($sformatf("tv%0d_count", i), 32'(fa.count), 32'(tv[i].cnt));
         chk($sformatf("tv%0d_full", i), 32'(fa.w_full), 32'(tv[i].full));
         chk($sformatf("tv%0d_ovf", i), 32'(fa.w_ovf), 32'(tv[i].ovf));
         chk($sformatf("tv%0d_rvalid", i), 32'(fa.r_valid), 32'(tv[i].rvalid));
         chk($sformatf("tv%0d_rdata", i), 32'(fa.r_data), 32'(tv[i].rdata));
      end

      do_reset();
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 8'(k), 1'b0);
         chk($sformatf("aempty_after_%0d", k), 32'(fa.r_aempty), 32'(k < 3));
         chk($sformatf("afull_after_%0d", k), 32'(fa.w_afull), 32'(k >= 6));
      end

      do_reset();
      for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0);
      for (int k = 0; k < 20; k++) cyc(1'b1, 8'(8'h50 + k), 1'b1);
      chk("simul_count4", 32'(fa.count), 32'd4);
      chk("simul_last_read", 32'(fa.r_data), 32'h5f);

      do_reset();
      cyc(1'b1, 8'h77, 1'b1);
      chk("empty_simul_unf", 32'(fa.r_unf), 32'd1);
      chk("empty_simul_count", 32'(fa.count), 32'd1);
      cyc(1'b0, 8'h00, 1'b0);
      chk("unf_one_cycle", 32'(fa.r_unf), 32'd0);
      for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0);
      cyc(1'b1, 8'hEE, 1'b1);
      chk("full_simul_ovf", 32'(fa.w_ovf), 32'd1);
      chk("full_simul_count", 32'(fa.count), 32'd7);
      chk("full_simul_rdata", 32'(fa.r_data), 32'h77);

      do_reset();
      cyc(1'b1, 8'hA5, 1'b0);
      chk("fwft_valid_a5", 32'(fb.r_valid), 32'd1);
      chk("fwft_data_a5", 32'(fb.r_data), 32'ha5);
      cyc(1'b0, 8'h00, 1'b1);
      chk("fwft_pop_empty", 32'(fb.r_empty), 32'd1);

      do_reset();
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h20 + k), 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      we = 1'b1; wd = 8'hFF;
      do_reset();
      we = 1'b0;
      chk("midrst_count", 32'(fa.count), 32'd0);
      chk("midrst_valid", 32'(fa.r_valid), 32'd0);
      cyc(1'b1, 8'h3C, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("after_rst_data", 32'(fa.r_data), 32'h3c);

      for (int b = 0; b < 6; b++) begin
         int wp;
         wp = (b % 2 == 1) ? 70 : 35;
         aft = 4'($urandom_range(0, 8));
         aet = 4'($urandom_range(0, 8));
         for (int k = 0; k < 60; k++)
            cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 50);
      end

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
